// File: rtl/rs_scheduler.sv
// Reservation-station control state: slot allocation, operand wakeup from the
// ALU/LSB broadcasts, and oldest-ready selection for ALU dispatch.
module rs_scheduler #(
    parameter int RS_SIZE   = 16,
    parameter int RS_WIDTH  = 4,
    parameter int ROB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  push,
    input  logic                  push_qj,
    input  logic [ROB_WIDTH-1:0]  push_qj_tag,
    input  logic                  push_qk,
    input  logic [ROB_WIDTH-1:0]  push_qk_tag,
    input  logic                  alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  alu_cdb_tag,
    input  logic                  lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  lsb_cdb_tag,
    input  logic                  rs_front,
    output logic                  rs_avail,
    output logic [RS_WIDTH-1:0]   rs_avail_pos,
    output logic                  rs_ready,
    output logic [RS_WIDTH-1:0]   rs_ready_pos,
    output logic [RS_WIDTH:0]     rs_count,
    output logic [RS_SIZE-1:0]    wake_j,
    output logic [RS_SIZE-1:0]    wake_k
);

    localparam logic [RS_WIDTH-1:0] AGE_MAX = RS_WIDTH'(RS_SIZE - 1);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj;
    logic [RS_SIZE-1:0]   qk;
    logic [ROB_WIDTH-1:0] tag_j [RS_SIZE];
    logic [ROB_WIDTH-1:0] tag_k [RS_SIZE];
    logic [RS_WIDTH-1:0]  age   [RS_SIZE];
    logic [RS_WIDTH:0]    count;

    logic                 push_acc;
    logic                 pop_acc;
    logic                 push_j_pend;
    logic                 push_k_pend;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_WIDTH-1:0]  best_age;

    function automatic logic tag_hit(
        input logic [ROB_WIDTH-1:0] tag,
        input logic                 a_vld,
        input logic [ROB_WIDTH-1:0] a_tag,
        input logic                 l_vld,
        input logic [ROB_WIDTH-1:0] l_tag
    );
        return (a_vld && (a_tag == tag)) || (l_vld && (l_tag == tag));
    endfunction

    function automatic logic [RS_WIDTH-1:0] age_inc(input logic [RS_WIDTH-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    // Free-slot offer and oldest-ready selection, both from registered state
    always_comb begin
        rs_avail     = 1'b0;
        rs_avail_pos = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                rs_avail     = 1'b1;
                rs_avail_pos = RS_WIDTH'(i);
            end
        end

        ready_vec    = busy & ~qj & ~qk;
        rs_ready     = 1'b0;
        rs_ready_pos = '0;
        best_age     = '0;
        // Strict '>' keeps the lowest index among equal ages
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_vec[i] && (!rs_ready || (age[i] > best_age))) begin
                rs_ready     = 1'b1;
                rs_ready_pos = RS_WIDTH'(i);
                best_age     = age[i];
            end
        end
    end

    always_comb begin
        wake_j = '0;
        wake_k = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j[i] = rdy && busy[i] && qj[i] &&
                        tag_hit(tag_j[i], alu_cdb_valid, alu_cdb_tag, lsb_cdb_valid, lsb_cdb_tag);
            wake_k[i] = rdy && busy[i] && qk[i] &&
                        tag_hit(tag_k[i], alu_cdb_valid, alu_cdb_tag, lsb_cdb_valid, lsb_cdb_tag);
        end
    end

    // A tag broadcast in the same cycle as the push is already resolved
    always_comb begin
        push_acc    = rdy && !rollback && push && rs_avail;
        pop_acc     = rdy && !rollback && rs_front && rs_ready;
        push_j_pend = push_qj &&
                      !tag_hit(push_qj_tag, alu_cdb_valid, alu_cdb_tag, lsb_cdb_valid, lsb_cdb_tag);
        push_k_pend = push_qk &&
                      !tag_hit(push_qk_tag, alu_cdb_valid, alu_cdb_tag, lsb_cdb_valid, lsb_cdb_tag);
    end

    assign rs_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            qj    <= '0;
            qk    <= '0;
            count <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                age[i] <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                busy  <= '0;
                qj    <= '0;
                qk    <= '0;
                count <= '0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    age[i] <= '0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (push_acc && (RS_WIDTH'(i) == rs_avail_pos)) begin
                        busy[i] <= 1'b1;
                        qj[i]   <= push_j_pend;
                        qk[i]   <= push_k_pend;
                        age[i]  <= '0;
                    end else begin
                        if (pop_acc && (RS_WIDTH'(i) == rs_ready_pos)) begin
                            busy[i] <= 1'b0;
                        end
                        if (wake_j[i]) begin
                            qj[i] <= 1'b0;
                        end
                        if (wake_k[i]) begin
                            qk[i] <= 1'b0;
                        end
                        if (push_acc && busy[i]) begin
                            age[i] <= age_inc(age[i]);
                        end
                    end
                end
                count <= count + (RS_WIDTH + 1)'(push_acc) - (RS_WIDTH + 1)'(pop_acc);
            end
        end
    end

    // Tags are only meaningful while the matching q bit is set, so they carry no reset
    always_ff @(posedge clk) begin
        if (push_acc) begin
            tag_j[rs_avail_pos] <= push_qj_tag;
            tag_k[rs_avail_pos] <= push_qk_tag;
        end
    end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Bookkeeping and selection controller for the reservation station array.
- Tracks per-slot busy state, operand-wait tags and age.
- Offers a free slot to the issue stage and picks the oldest operand-complete slot for dispatch to the ALU.
- Snoops the ALU and LSB result broadcasts to wake waiting operands; flushes on branch rollback. Entry payload (op, imm, values) stays in the RS storage array; this block holds only control state.

Parameters:
RS_SIZE, 16, number of reservation station slots (power of two)
RS_WIDTH, 4, log2(RS_SIZE); slot index width
ROB_WIDTH, 4, ROB index width used as wakeup tag

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
rdy  input  1  global enable; when 0 all state holds
rollback  input  1  flush all slots (mispredict)
push  input  1  issue allocates slot rs_avail_pos this cycle
push_qj  input  1  operand j pending
push_qj_tag  input  ROB_WIDTH  ROB position producing operand j
push_qk  input  1  operand k pending
push_qk_tag  input  ROB_WIDTH  ROB position producing operand k
alu_cdb_valid  input  1  ALU result broadcast valid
alu_cdb_tag  input  ROB_WIDTH  ROB position of ALU result
lsb_cdb_valid  input  1  LSB result broadcast valid
lsb_cdb_tag  input  ROB_WIDTH  ROB position of LSB result
rs_front  input  1  ALU consumed slot rs_ready_pos this cycle
rs_avail  output  1  at least one free slot
rs_avail_pos  output  RS_WIDTH  lowest-index free slot (0 when none)
rs_ready  output  1  at least one busy slot with both operands present
rs_ready_pos  output  RS_WIDTH  selected ready slot (0 when none)
rs_count  output  RS_WIDTH+1  number of busy slots
wake_j  output  RS_SIZE  per-slot strobe: operand j captured from CDB this cycle
wake_k  output  RS_SIZE  per-slot strobe: operand k captured from CDB this cycle

Behaviour:
- Per-slot state: busy, qj, tag_j, qk, tag_k, age[RS_WIDTH-1:0].
- Reset (async): all busy/qj/qk/age cleared; rs_avail=1, rs_avail_pos=0, rs_ready=0, rs_ready_pos=0, rs_count=0, wake_j=wake_k=0.
- Outputs are combinational from registered state; zero-cycle offer, one-cycle update.
- rdy=0: no state change; push/rs_front/CDB ignored; wake_* forced 0.
- Priority: rollback > all. Rollback clears every busy/q/age at the clock edge; same-cycle push and pop are discarded.
- Push: slot rs_avail_pos becomes busy with qj/qk/tags from inputs and age 0. Push while rs_avail=0 is ignored (protocol error; no state change).
- Push bypass: if a pending push tag equals a valid CDB tag in the same cycle, that operand is written as not pending.
- Wakeup: for each busy slot with qj=1 and tag_j matching a valid alu or lsb tag, clear qj next edge and assert wake_j[slot] combinationally this cycle. Same for k. Both CDBs may wake different or the same operands in one cycle.
- Ready condition: busy && !qj && !qk, evaluated on registered state. A slot woken this cycle becomes selectable next cycle.
- Selection: the ready slot with the largest age; ties go to the lowest index.
- Age: on every accepted push, every other busy slot increments age, saturating at RS_SIZE-1. Ages do not change on pop or idle cycles.
- Pop: rs_front with rs_ready=1 clears busy for slot rs_ready_pos. rs_front with rs_ready=0 is ignored.
- Simultaneous push+pop: both applied. The pushed slot is never the popped slot, because rs_avail_pos is always a non-busy slot.
- rs_count next = count + push_accepted - pop_accepted; range 0..RS_SIZE.
- Full: rs_avail=0 and rs_avail_pos=0 when count==RS_SIZE. Push+pop in the full state is impossible because the push is not accepted.

Test Plan:
- Reset then idle -> rs_avail=1, rs_avail_pos=0, rs_ready=0, rs_count=0.
- Push 3 ready entries (qj=qk=0) into slots 0,1,2; pulse rs_front each cycle -> rs_ready_pos sequence 0,1,2 (oldest first); rs_count returns to 0.
- Push slot0 with qj=1, tag_j=5; push slot1 ready; alu_cdb_valid=1, tag 5 -> wake_j[0]=1 that cycle; slot1 selected first; slot0 becomes ready next cycle.
- Push with qk=1, tag_k=3 while lsb_cdb_valid=1, tag 3 in the same cycle -> entry ready the next cycle with no wake_k pulse.
- Fill all 16 slots -> rs_avail=0, rs_count=16. Pop slot 7 -> rs_avail=1, rs_avail_pos=7. Push+pop in one cycle -> count holds.
- With 5 busy slots, assert rollback together with push and rs_front -> all slots free, rs_count=0, rs_ready=0. Separately, assert rst mid-sequence -> outputs return to reset values immediately, without waiting for a clock edge.
